frog_controller: RTL and testbench

Player-movement and game-progress stage that sits directly upstream of the VGA display controller. It synchronises and debounces four raw push-buttons and moves the frog in 32-pixel hops inside the 640x480 playfield. It tracks the frog's facing direction, returns the frog to the start position on collision or on reaching the top row, and advances the game level. Its outputs drive the display controller's frog_x, frog_y, frog_direction and current_level inputs.

---
 rtl/frog_controller.sv | 239 +++++++++++++++++++++++
 tb/tb_frog_controller.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/frog_controller.sv
// Frog movement/game-progress stage: button conditioning, hop FSM, respawn and level tracking.
// Optional FROG_LIVES_EN adds a lives counter with game-over reset of the level.
module frog_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned HOP_COOLDOWN    = 2500000,
    parameter int unsigned STEP            = 32,
    parameter int unsigned H_DISPLAY       = 640,
    parameter int unsigned V_DISPLAY       = 480,
    parameter int unsigned MAX_LEVEL       = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       collision,
    output logic [9:0] frog_x,
    output logic [9:0] frog_y,
    output logic [1:0] frog_direction,
    output logic [3:0] current_level,
    output logic       level_up,
    output logic       death
`ifdef FROG_LIVES_EN
    ,
    output logic [1:0] lives
`endif
);

    localparam int unsigned POS_W = 10;
    localparam int unsigned LVL_W = 4;
    localparam int unsigned NBTN  = 4;
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned CD_W  = (HOP_COOLDOWN > 1) ? $clog2(HOP_COOLDOWN) : 1;

    localparam logic [POS_W-1:0] START_X = POS_W'((H_DISPLAY - STEP) / 2);
    localparam logic [POS_W-1:0] START_Y = POS_W'(V_DISPLAY - STEP);
    localparam logic [POS_W-1:0] STEP_P  = POS_W'(STEP);
    localparam logic [POS_W-1:0] MAX_HX  = POS_W'(H_DISPLAY - 2 * STEP);
    localparam logic [POS_W-1:0] MAX_HY  = POS_W'(V_DISPLAY - 2 * STEP);
    localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(MAX_LEVEL);
    localparam logic [CNT_W-1:0] DEB_END = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CD_W-1:0]  CD_END  = CD_W'(HOP_COOLDOWN - 1);

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    typedef enum logic [1:0] {IDLE, HOP, COOLDOWN, RESPAWN} state_t;

    state_t state, state_next;

    logic [NBTN-1:0]  btn_raw_c;
    logic [NBTN-1:0]  sync_a, sync_b, deb, deb_prev;
    logic [CNT_W-1:0] deb_cnt [NBTN];
    logic [NBTN-1:0]  press_c;
    logic             press_any_c;
    logic [1:0]       press_dir_c;

    logic [1:0]       hop_dir, hop_dir_next;
    logic             win, win_next;
    logic [CD_W-1:0]  cd_cnt, cd_next;
    logic [POS_W-1:0] x_next, y_next;
    logic [1:0]       dir_next;
    logic [LVL_W-1:0] level_next;
    logic             level_up_next, death_next;
`ifdef FROG_LIVES_EN
    logic [1:0]       lives_next;
`endif

    // Bit order: 0 up, 1 down, 2 left, 3 right (also the press priority order).
    assign btn_raw_c = {btn_right, btn_left, btn_down, btn_up};

    // Two-flop synchroniser plus per-button stability counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_a   <= '0;
            sync_b   <= '0;
            deb      <= '0;
            deb_prev <= '0;
            for (int i = 0; i < int'(NBTN); i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            sync_a   <= btn_raw_c;
            sync_b   <= sync_a;
            deb_prev <= deb;
            for (int i = 0; i < int'(NBTN); i++) begin
                if (sync_b[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_END) begin
                    deb[i]     <= sync_b[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign press_c     = deb & ~deb_prev;
    assign press_any_c = |press_c;

    // Single press selection, up > down > left > right.
    always_comb begin
        press_dir_c = DIR_UP;
        if (press_c[0]) begin
            press_dir_c = DIR_UP;
        end else if (press_c[1]) begin
            press_dir_c = DIR_DOWN;
        end else if (press_c[2]) begin
            press_dir_c = DIR_LEFT;
        end else if (press_c[3]) begin
            press_dir_c = DIR_RIGHT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and next-output logic; a collision outside RESPAWN overrides everything.
    always_comb begin
        state_next    = state;
        hop_dir_next  = hop_dir;
        win_next      = win;
        cd_next       = cd_cnt;
        x_next        = frog_x;
        y_next        = frog_y;
        dir_next      = frog_direction;
        level_next    = current_level;
        level_up_next = 1'b0;
        death_next    = 1'b0;
`ifdef FROG_LIVES_EN
        lives_next    = lives;
`endif
        case (state)
            IDLE: begin
                if (collision) begin
                    state_next = RESPAWN;
                    win_next   = 1'b0;
                end else if (press_any_c) begin
                    state_next   = HOP;
                    hop_dir_next = press_dir_c;
                end
            end
            HOP: begin
                if (collision) begin
                    state_next = RESPAWN;
                    win_next   = 1'b0;
                end else begin
                    dir_next   = hop_dir;
                    cd_next    = '0;
                    win_next   = 1'b0;
                    state_next = COOLDOWN;
                    unique case (hop_dir)
                        DIR_UP:    if (frog_y >= STEP_P) y_next = frog_y - STEP_P;
                        DIR_DOWN:  if (frog_y <= MAX_HY) y_next = frog_y + STEP_P;
                        DIR_LEFT:  if (frog_x >= STEP_P) x_next = frog_x - STEP_P;
                        DIR_RIGHT: if (frog_x <= MAX_HX) x_next = frog_x + STEP_P;
                    endcase
                    if (y_next == '0) begin
                        state_next = RESPAWN;
                        win_next   = 1'b1;
                    end
                end
            end
            COOLDOWN: begin
                if (collision) begin
                    state_next = RESPAWN;
                    win_next   = 1'b0;
                end else if (cd_cnt == CD_END) begin
                    state_next = IDLE;
                end else begin
                    cd_next = cd_cnt + 1'b1;
                end
            end
            RESPAWN: begin
                x_next     = START_X;
                y_next     = START_Y;
                dir_next   = DIR_UP;
                cd_next    = '0;
                win_next   = 1'b0;
                state_next = COOLDOWN;
                if (win) begin
                    level_up_next = 1'b1;
                    if (current_level < LVL_MAX) level_next = current_level + 1'b1;
                end else begin
                    death_next = 1'b1;
`ifdef FROG_LIVES_EN
                    if (lives == 2'd1) begin
                        lives_next = 2'd3;
                        level_next = LVL_W'(1);
                    end else begin
                        lives_next = lives - 1'b1;
                    end
`endif
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hop_dir        <= DIR_UP;
            win            <= 1'b0;
            cd_cnt         <= '0;
            frog_x         <= START_X;
            frog_y         <= START_Y;
            frog_direction <= DIR_UP;
            current_level  <= LVL_W'(1);
            level_up       <= 1'b0;
            death          <= 1'b0;
`ifdef FROG_LIVES_EN
            lives          <= 2'd3;
`endif
        end else begin
            hop_dir        <= hop_dir_next;
            win            <= win_next;
            cd_cnt         <= cd_next;
            frog_x         <= x_next;
            frog_y         <= y_next;
            frog_direction <= dir_next;
            current_level  <= level_next;
            level_up       <= level_up_next;
            death          <= death_next;
`ifdef FROG_LIVES_EN
            lives          <= lives_next;
`endif
        end
    end

endmodule

// File: tb/tb_frog_controller.sv
// Directed bench for frog_controller with short debounce and cooldown.
module tb_frog_controller;

    localparam int unsigned DEB = 4;
    localparam int unsigned CD  = 8;

    localparam int B_UP    = 0;
    localparam int B_DOWN  = 1;
    localparam int B_LEFT  = 2;
    localparam int B_RIGHT = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_up, btn_down, btn_left, btn_right;
    logic       collision;
    logic [9:0] frog_x, frog_y;
    logic [1:0] frog_direction;
    logic [3:0] current_level;
    logic       level_up, death;
`ifdef FROG_LIVES_EN
    logic [1:0] lives;
`endif

    int checks = 0;
    int errors = 0;
    int lu_cnt = 0;
    int death_cnt = 0;
    int lu0, d0;

    frog_controller #(
        .DEBOUNCE_CYCLES(DEB),
        .HOP_COOLDOWN(CD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_up(btn_up),
        .btn_down(btn_down),
        .btn_left(btn_left),
        .btn_right(btn_right),
        .collision(collision),
        .frog_x(frog_x),
        .frog_y(frog_y),
        .frog_direction(frog_direction),
        .current_level(current_level),
        .level_up(level_up),
        .death(death)
`ifdef FROG_LIVES_EN
        ,
        .lives(lives)
`endif
    );

    always #5 clk = ~clk;

    // Count high cycles of the pulse outputs so a stretched pulse shows up as an extra count.
    always @(negedge clk) begin
        if (level_up) lu_cnt <= lu_cnt + 1;
        if (death) death_cnt <= death_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_btns(input logic [3:0] v);
        {btn_right, btn_left, btn_down, btn_up} = v;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        set_btns(4'b0000);
        collision = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic hop(input int b);
        logic [3:0] v;
        v = 4'b0000;
        v[b] = 1'b1;
        @(negedge clk);
        set_btns(v);
        repeat (12) @(negedge clk);
        set_btns(4'b0000);
        repeat (20) @(negedge clk);
    endtask

    task automatic win_once();
        for (int i = 0; i < 14; i++) hop(B_UP);
    endtask

    task automatic pulse_collision();
        @(negedge clk);
        collision = 1'b1;
        @(negedge clk);
        collision = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        collision = 1'b0;
        set_btns(4'b0000);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check_eq("reset_x", 32'(frog_x), 32'd304);
        check_eq("reset_y", 32'(frog_y), 32'd448);
        check_eq("reset_dir", 32'(frog_direction), 32'd0);
        check_eq("reset_level", 32'(current_level), 32'd1);
        check_eq("reset_level_up", 32'(level_up), 32'd0);
        check_eq("reset_death", 32'(death), 32'd0);
`ifdef FROG_LIVES_EN
        check_eq("reset_lives", 32'(lives), 32'd3);
`endif

        // Held button hops exactly once.
        @(negedge clk);
        set_btns(4'b0001);
        repeat (20) @(negedge clk);
        set_btns(4'b0000);
        repeat (20) @(negedge clk);
        check_eq("hold_up_y", 32'(frog_y), 32'd416);
        check_eq("hold_up_x", 32'(frog_x), 32'd304);
        check_eq("hold_up_dir", 32'(frog_direction), 32'd0);

        // Short bounce is rejected, then a real press moves left.
        @(negedge clk);
        set_btns(4'b0100);
        repeat (2) @(negedge clk);
        set_btns(4'b0000);
        repeat (20) @(negedge clk);
        check_eq("bounce_x", 32'(frog_x), 32'd304);
        check_eq("bounce_dir", 32'(frog_direction), 32'd0);
        @(negedge clk);
        set_btns(4'b0100);
        repeat (10) @(negedge clk);
        set_btns(4'b0000);
        repeat (20) @(negedge clk);
        check_eq("left_x", 32'(frog_x), 32'd272);
        check_eq("left_dir", 32'(frog_direction), 32'd3);

        // Simultaneous up+right: up wins.
        do_reset();
        @(negedge clk);
        set_btns(4'b1001);
        repeat (12) @(negedge clk);
        set_btns(4'b0000);
        repeat (20) @(negedge clk);
        check_eq("prio_y", 32'(frog_y), 32'd416);
        check_eq("prio_x", 32'(frog_x), 32'd304);
        check_eq("prio_dir", 32'(frog_direction), 32'd0);

        // Left edge: 304 - 9*32 = 16; a further left only turns the frog.
        do_reset();
        for (int i = 0; i < 9; i++) hop(B_LEFT);
        check_eq("left_edge_x", 32'(frog_x), 32'd16);
        hop(B_UP);
        hop(B_LEFT);
        check_eq("left_blocked_x", 32'(frog_x), 32'd16);
        check_eq("left_blocked_dir", 32'(frog_direction), 32'd3);
        check_eq("left_blocked_y", 32'(frog_y), 32'd416);

        // Right edge: 16 + 18*32 = 592; a further right only turns the frog.
        for (int i = 0; i < 18; i++) hop(B_RIGHT);
        check_eq("right_edge_x", 32'(frog_x), 32'd592);
        hop(B_UP);
        hop(B_RIGHT);
        check_eq("right_blocked_x", 32'(frog_x), 32'd592);
        check_eq("right_blocked_dir", 32'(frog_direction), 32'd1);
        check_eq("right_blocked_y", 32'(frog_y), 32'd384);

        // Down hop from bottom row is blocked.
        do_reset();
        hop(B_DOWN);
        check_eq("down_blocked_y", 32'(frog_y), 32'd448);
        check_eq("down_blocked_dir", 32'(frog_direction), 32'd2);

        // First win: level 1 -> 2 with a single level_up cycle.
        do_reset();
        lu0 = lu_cnt;
        d0 = death_cnt;
        for (int i = 0; i < 13; i++) hop(B_UP);
        check_eq("pre_win_y", 32'(frog_y), 32'd32);
        check_eq("pre_win_level", 32'(current_level), 32'd1);
        hop(B_UP);
        check_eq("win_level_up_cycles", 32'(lu_cnt - lu0), 32'd1);
        check_eq("win_level", 32'(current_level), 32'd2);
        check_eq("win_x", 32'(frog_x), 32'd304);
        check_eq("win_y", 32'(frog_y), 32'd448);
        check_eq("win_dir", 32'(frog_direction), 32'd0);
        check_eq("win_no_death", 32'(death_cnt - d0), 32'd0);

        // Climb to level 9, then one more win saturates.
        for (int w = 0; w < 7; w++) win_once();
        check_eq("level9", 32'(current_level), 32'd9);
        lu0 = lu_cnt;
        win_once();
        check_eq("sat_level", 32'(current_level), 32'd9);
        check_eq("sat_level_up_cycles", 32'(lu_cnt - lu0), 32'd1);

        // Collision aligned with the winning hop's entry: death, no win.
        for (int i = 0; i < 13; i++) hop(B_UP);
        check_eq("pre_coll_y", 32'(frog_y), 32'd32);
        lu0 = lu_cnt;
        d0 = death_cnt;
        @(negedge clk);
        set_btns(4'b0001);
        repeat (6) @(negedge clk);
        collision = 1'b1;
        @(negedge clk);
        collision = 1'b0;
        repeat (6) @(negedge clk);
        set_btns(4'b0000);
        repeat (20) @(negedge clk);
        check_eq("coll_death_cycles", 32'(death_cnt - d0), 32'd1);
        check_eq("coll_no_level_up", 32'(lu_cnt - lu0), 32'd0);
        check_eq("coll_level", 32'(current_level), 32'd9);
        check_eq("coll_x", 32'(frog_x), 32'd304);
        check_eq("coll_y", 32'(frog_y), 32'd448);
        check_eq("coll_dir", 32'(frog_direction), 32'd0);
`ifdef FROG_LIVES_EN
        check_eq("coll_lives", 32'(lives), 32'd2);
`endif

        // Reset during cooldown restores start state.
        do_reset();
        @(negedge clk);
        set_btns(4'b0001);
        repeat (9) @(negedge clk);
        check_eq("mid_cd_y", 32'(frog_y), 32'd416);
        reset = 1'b1;
        set_btns(4'b0000);
        @(negedge clk);
        reset = 1'b0;
        check_eq("mid_cd_reset_y", 32'(frog_y), 32'd448);
        check_eq("mid_cd_reset_level", 32'(current_level), 32'd1);
        repeat (20) @(negedge clk);
        check_eq("mid_cd_settled_y", 32'(frog_y), 32'd448);

`ifdef FROG_LIVES_EN
        // Three deaths: 3 -> 2 -> 1 -> 3 with level back to 1.
        do_reset();
        win_once();
        check_eq("lives_pre_level", 32'(current_level), 32'd2);
        pulse_collision();
        check_eq("lives_after1", 32'(lives), 32'd2);
        check_eq("lives_level1", 32'(current_level), 32'd2);
        pulse_collision();
        check_eq("lives_after2", 32'(lives), 32'd1);
        pulse_collision();
        check_eq("lives_after3", 32'(lives), 32'd3);
        check_eq("lives_game_over_level", 32'(current_level), 32'd1);
`else
        // Deaths leave the level alone.
        do_reset();
        win_once();
        pulse_collision();
        pulse_collision();
        pulse_collision();
        check_eq("death_keeps_level", 32'(current_level), 32'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
